// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modexp_pkg
// Description : Shared defaults and FSM state type for the modexp arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    localparam int c_WIDTH   = 32;
    localparam int c_NREQ    = 4;
    localparam int c_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage : modexp_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; one-hot grant to the first
//               requester at or after the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import modexp_pkg::*;
#(
    parameter int NREQ  = c_NREQ,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant
);

    logic [NREQ-1:0]   w_rot;
    logic [NREQ-1:0]   w_rot_gnt;
    logic [2*NREQ-1:0] w_gnt_dbl;

    // Rotate so the pointer lands on bit 0, take the lowest set bit, rotate back.
    assign w_rot     = NREQ'({i_req, i_req} >> i_ptr);
    assign w_rot_gnt = w_rot & (-w_rot);
    assign w_gnt_dbl = {{NREQ{1'b0}}, w_rot_gnt} << i_ptr;
    assign o_grant   = w_gnt_dbl[NREQ-1:0] | w_gnt_dbl[2*NREQ-1:NREQ];

endmodule : rr_picker
`default_nettype wire

// File: rtl/modexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : modexp_arbiter
// Description : Shares one modular-exponentiation engine among NREQ
//               requesters with round-robin arbitration and a run timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_arbiter
    import modexp_pkg::*;
#(
    parameter int WIDTH   = c_WIDTH,
    parameter int NREQ    = c_NREQ,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_base,
    input  logic [NREQ*WIDTH-1:0] req_exp,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_start,
    output logic [WIDTH-1:0]      eng_base,
    output logic [WIDTH-1:0]      eng_exp,
    input  logic                  eng_done,
    input  logic [WIDTH-1:0]      eng_result
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [c_PTR_W-1:0] r_ptr;
    logic [NREQ-1:0]    r_win;
    logic [c_CNT_W-1:0] r_cnt;

    logic [NREQ-1:0]    w_grant;
    logic [WIDTH-1:0]   w_sel_base;
    logic [WIDTH-1:0]   w_sel_exp;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [WIDTH-1:0]   w_base_arr [NREQ];
    logic [WIDTH-1:0]   w_exp_arr  [NREQ];

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_rr_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_base_arr[g] = req_base[g*WIDTH +: WIDTH];
        assign w_exp_arr[g]  = req_exp[g*WIDTH +: WIDTH];
    end

    // Grant is one-hot, so OR-ing the masked slices acts as the operand mux.
    always_comb begin
        w_sel_base = '0;
        w_sel_exp  = '0;
        w_next_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_base = w_sel_base | w_base_arr[i];
                w_sel_exp  = w_sel_exp | w_exp_arr[i];
                w_next_ptr = (i == NREQ - 1) ? '0 : c_PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_cnt      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            eng_start  <= 1'b0;
            eng_base   <= '0;
            eng_exp    <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_state   <= RUN;
                        busy      <= 1'b1;
                        req_ready <= w_grant;
                        r_win     <= w_grant;
                        r_ptr     <= w_next_ptr;
                        eng_base  <= w_sel_base;
                        eng_exp   <= w_sel_exp;
                        eng_start <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        eng_start  <= 1'b0;
                        rsp_result <= eng_result;
                        rsp_valid  <= r_win;
                        r_state    <= RESP;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        eng_start  <= 1'b0;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= r_win;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    // Wait out a done level still held from the finished operation.
                    if (!eng_done) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    eng_start <= 1'b0;
                end
            endcase
        end
    end

endmodule : modexp_arbiter
`default_nettype wire

// File: tb/tb_modexp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modexp_arbiter
// Description : Self-checking bench for modexp_arbiter with a behavioural
//               engine model and a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_arbiter;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam longint unsigned MOD = 64'd998244353;
    localparam int M_NORMAL = 0;
    localparam int M_STALE  = 1;
    localparam int M_NEVER  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_base;
    logic [NREQ*WIDTH-1:0] req_exp;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  busy;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_base;
    logic [WIDTH-1:0]      eng_exp;
    logic                  eng_done = 1'b0;
    logic [WIDTH-1:0]      eng_result = '0;

    logic [WIDTH-1:0] op_base [NREQ];
    logic [WIDTH-1:0] op_exp  [NREQ];

    int eng_mode = M_NORMAL;
    int eng_lat  = 2;
    int eng_cnt  = 0;
    int eng_hold = 0;
    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int model_ptr = 0;

    int               got_who [$];
    logic [WIDTH-1:0] got_res [$];
    logic             got_err [$];
    int               exp_who [$];
    logic [WIDTH-1:0] exp_res [$];
    logic             exp_err [$];
    int               acc_cyc [$];

    typedef struct {
        int               rq;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] e;
        int               mode;
        logic [WIDTH-1:0] res;
        logic             err;
    } vec_t;

    vec_t tbl [5];

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign req_base[g*WIDTH +: WIDTH] = op_base[g];
        assign req_exp[g*WIDTH +: WIDTH]  = op_exp[g];
    end

    modexp_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_base   (req_base),
        .req_exp    (req_exp),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_exp    (eng_exp),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [WIDTH-1:0] ref_modexp(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e);
        longint unsigned r, x;
        logic [WIDTH-1:0] ee;
        r  = 1;
        x  = 64'(b) % MOD;
        ee = e;
        for (int i = 0; i < WIDTH; i++) begin
            if (ee[0]) r = (r * x) % MOD;
            x  = (x * x) % MOD;
            ee = ee >> 1;
        end
        return WIDTH'(r);
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] m);
        logic [NREQ-1:0] t;
        for (int k = 0; k < NREQ; k++) begin
            t = m >> ((ptr + k) % NREQ);
            if (t[0]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Engine: finishes eng_lat cycles after start; STALE keeps done up after start drops.
    always @(negedge clk) begin
        if (rst) begin
            eng_done = 1'b0;
            eng_cnt  = 0;
            eng_hold = 0;
        end else if (eng_start && !eng_done) begin
            eng_cnt++;
            if (eng_mode != M_NEVER && eng_cnt >= eng_lat) begin
                eng_result = ref_modexp(eng_base, eng_exp);
                eng_done   = 1'b1;
                eng_hold   = (eng_mode == M_STALE) ? 2 : 0;
            end
        end else if (!eng_start) begin
            eng_cnt = 0;
            if (eng_done) begin
                if (eng_hold > 0) eng_hold--;
                else eng_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  req_ready,  0);
        check({tag, "_rsp_valid"},  rsp_valid,  0);
        check({tag, "_rsp_err"},    rsp_err,    0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_eng_start"},  eng_start,  0);
        check({tag, "_eng_base"},   eng_base,   0);
        check({tag, "_eng_exp"},    eng_exp,    0);
        check({tag, "_rsp_result"}, rsp_result, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Raise the masked requests and follow them to completion against the models.
    task automatic serve(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0]  pend, onehot;
        logic [WIDTH-1:0] er;
        logic             ee;
        int               w, budget, idle_cyc, ac;
        got_who.delete(); got_res.delete(); got_err.delete();
        exp_who.delete(); exp_res.delete(); exp_err.delete(); acc_cyc.delete();
        pend = mask;
        req_valid = pend;
        budget = 3000;
        idle_cyc = cyc;
        while ((pend != '0 || exp_who.size() != 0 || busy) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
            check("ready_onehot0", 64'($onehot0(req_ready)), 1);
            check("rsp_onehot0", 64'($onehot0(rsp_valid)), 1);
            if (!busy && req_ready == '0) idle_cyc = cyc;
            if (req_ready != '0) begin
                w = rr_pick(model_ptr, pend);
                onehot = (w >= 0) ? (NREQ'(1) << w) : '0;
                check("accept_grant", req_ready, onehot);
                check("accept_latency", cyc - idle_cyc, 1);
                check("accept_start", eng_start, 1);
                if (w >= 0) begin
                    check("accept_base", eng_base, op_base[w]);
                    check("accept_exp", eng_exp, op_exp[w]);
                    exp_who.push_back(w);
                    exp_res.push_back((eng_mode == M_NEVER) ? '0 : ref_modexp(op_base[w], op_exp[w]));
                    exp_err.push_back(eng_mode == M_NEVER);
                    acc_cyc.push_back(cyc);
                    pend = pend & ~onehot;
                    req_valid = pend;
                    model_ptr = (w + 1) % NREQ;
                end
            end
            if (rsp_valid != '0) begin
                check("rsp_start_low", eng_start, 0);
                if (exp_who.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    w  = exp_who.pop_front();
                    er = exp_res.pop_front();
                    ee = exp_err.pop_front();
                    ac = acc_cyc.pop_front();
                    check("rsp_who", rsp_valid, NREQ'(1) << w);
                    check("rsp_result", rsp_result, er);
                    check("rsp_err", rsp_err, ee);
                    if (ee) check("timeout_cycles", cyc - ac, TIMEOUT);
                    got_who.push_back($clog2(rsp_valid));
                    got_res.push_back(rsp_result);
                    got_err.push_back(rsp_err);
                end
            end else begin
                check("rsp_err_idle", rsp_err, 0);
            end
        end
        check("serve_pending", pend, 0);
        check("serve_outstanding", exp_who.size(), 0);
        check("serve_idle", busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_rr [4];
        logic [WIDTH-1:0] exp_rr_res [4];
        int cnt;
        logic [NREQ-1:0] mask;

        for (int i = 0; i < NREQ; i++) begin
            op_base[i] = '0;
            op_exp[i]  = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_ptr = 0;

        // Table of single requests
        tbl[0] = '{0, 32'd2,         32'd10, M_NORMAL, 32'd1024, 1'b0};
        tbl[1] = '{2, 32'd5,         32'd0,  M_NORMAL, 32'd1,    1'b0};
        tbl[2] = '{1, 32'd998244352, 32'd2,  M_NORMAL, 32'd1,    1'b0};
        tbl[3] = '{3, 32'd7,         32'd3,  M_STALE,  32'd343,  1'b0};
        tbl[4] = '{0, 32'd4,         32'd5,  M_NEVER,  32'd0,    1'b1};
        for (int t = 0; t < 5; t++) begin
            op_base[tbl[t].rq] = tbl[t].b;
            op_exp[tbl[t].rq]  = tbl[t].e;
            eng_mode = tbl[t].mode;
            eng_lat  = 3;
            serve(NREQ'(1) << tbl[t].rq);
            check("tbl_count", got_who.size(), 1);
            if (got_who.size() > 0) begin
                check("tbl_who", got_who[0], tbl[t].rq);
                check("tbl_result", got_res[0], tbl[t].res);
                check("tbl_err", got_err[0], tbl[t].err);
            end
        end

        // Stale done with a second requester waiting during DRAIN
        eng_mode = M_STALE;
        eng_lat  = 3;
        op_base[0] = 32'd2; op_exp[0] = 32'd3;
        op_base[1] = 32'd2; op_exp[1] = 32'd4;
        serve(4'b0011);
        check("stale_count", got_res.size(), 2);
        if (got_res.size() == 2) begin
            check("stale_res0", got_res[0] + got_res[1], 32'd24);
            check("stale_distinct", got_res[0] != got_res[1], 1);
        end
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid != '0) cnt++;
        end
        check("stale_no_extra_rsp", cnt, 0);

        // Round-robin from a fresh reset
        do_reset();
        eng_mode = M_NORMAL;
        eng_lat  = 2;
        for (int i = 0; i < NREQ; i++) begin
            op_base[i] = 32'd3;
            op_exp[i]  = WIDTH'(i + 1);
        end
        exp_rr = '{0, 1, 2, 3};
        exp_rr_res = '{32'd3, 32'd9, 32'd27, 32'd81};
        serve(4'b1111);
        check("rr_count", got_who.size(), 4);
        for (int k = 0; k < 4 && k < got_who.size(); k++) begin
            check("rr_order", got_who[k], exp_rr[k]);
            check("rr_result", got_res[k], exp_rr_res[k]);
        end
        serve(4'b1010);
        check("rr2_count", got_who.size(), 2);
        if (got_who.size() == 2) begin
            check("rr2_first", got_who[0], 1);
            check("rr2_second", got_who[1], 3);
            check("rr2_res_first", got_res[0], 32'd9);
        end

        // Reset in the middle of a run
        serve(4'b0010);
        eng_mode = M_NEVER;
        req_valid = 4'b0100;
        cnt = 0;
        while (req_ready == '0 && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("mr_accept", req_ready, 4'b0100);
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        check("mr_running", {busy, eng_start}, 2'b11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
        check_all_zero("midrst");
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid != '0 || busy) cnt++;
        end
        check("mr_quiet", cnt, 0);
        eng_mode = M_NORMAL;
        serve(4'b0111);
        check("mr_count", got_who.size(), 3);
        if (got_who.size() > 0) check("mr_first", got_who[0], 0);

        // Randomized groups against the reference models
        for (int it = 0; it < 25; it++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                op_base[i] = ($urandom_range(0, 3) == 0) ? WIDTH'(MOD - 1) : WIDTH'($urandom);
                op_exp[i]  = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 20));
            end
            cnt = $urandom_range(0, 9);
            eng_mode = (cnt == 0) ? M_NEVER : (cnt < 4) ? M_STALE : M_NORMAL;
            eng_lat  = $urandom_range(1, 6);
            serve(mask);
            check("rand_count", got_who.size(), $countones(mask));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_modexp_arbiter
`default_nettype wire

// File: doc/modexp_arbiter.md
MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 32, operand/result width.
- NREQ, 4, number of requesters.
- TIMEOUT, 64, max cycles from eng_start rise to eng_done.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, NREQ, per-requester operation request.
- req_base, in, NREQ*WIDTH, per-requester base; slice i belongs to requester i.
- req_exp, in, NREQ*WIDTH, per-requester exponent; slice i belongs to requester i.
- req_ready, out, NREQ, one-cycle acceptance pulse.
- rsp_valid, out, NREQ, one-cycle result pulse.
- rsp_result, out, WIDTH, shared result bus, valid with any rsp_valid bit.
- rsp_err, out, 1, timeout flag, valid with rsp_valid.
- busy, out, 1, high in any state other than IDLE.
- eng_start, out, 1, engine start level.
- eng_base, out, WIDTH, engine base operand.
- eng_exp, out, WIDTH, engine exponent operand.
- eng_done, in, 1, engine done level.
- eng_result, in, WIDTH, engine result.

Function
REQ-003 The block shall share one modular-exponentiation engine among NREQ requesters, one operation at a time.
REQ-004 The FSM shall have states IDLE, RUN, RESP and DRAIN.
REQ-005 IDLE: if any req_valid bit is high, the block shall pick the winner w by round-robin and go to RUN next cycle.
REQ-006 On entering RUN, the block shall:
- latch req_base[w] into eng_base and req_exp[w] into eng_exp;
- assert eng_start;
- pulse req_ready[w] for exactly one cycle.
REQ-007 Round-robin order shall start at the requester after the last winner; after reset, requester 0 has highest priority.
REQ-008 A requester shall hold req_valid and its operands stable until its req_ready pulse; the bench shall treat a drop before acceptance as a protocol violation.
REQ-009 RUN: eng_start shall stay high until eng_done is sampled high; eng_base and eng_exp shall stay stable throughout RUN.
REQ-010 RUN with eng_done=1: the block shall drop eng_start, capture eng_result and go to RESP.
REQ-011 RESP, one cycle: rsp_valid[w]=1, rsp_result=captured value, rsp_err=0; next state DRAIN.
REQ-012 DRAIN: eng_start shall be 0; the block shall return to IDLE on the first cycle eng_done is sampled 0, so a stale done is never taken as a new completion.
REQ-013 A cycle counter shall clear on RUN entry and increment each RUN cycle.
REQ-014 If the counter reaches TIMEOUT with eng_done still 0, the block shall drop eng_start and enter RESP with rsp_result=0 and rsp_err=1.
REQ-015 Outside RESP, rsp_valid shall be all-zero and rsp_err shall be 0; rsp_result shall hold its last value.
REQ-016 req_ready and rsp_valid shall each be one-hot or all-zero in every cycle.
REQ-017 Minimum request-to-accept latency shall be 1 cycle (request sampled in IDLE at T, req_ready at T+1).
REQ-018 Back-to-back requests: a new acceptance shall occur no earlier than 2 cycles after DRAIN exits.
REQ-019 A req_valid bit that is already high during RUN, RESP or DRAIN shall be considered at the next IDLE.

Reset
REQ-020 When rst is high at a clock edge, all of the following shall take effect that cycle:
- state becomes IDLE and the round-robin pointer returns to requester 0;
- req_ready, rsp_valid, rsp_err, busy and eng_start become 0;
- eng_base, eng_exp and rsp_result become 0.
REQ-021 Reset mid-operation shall abandon the operation with no rsp_valid pulse; the engine shares the same rst.

Structure
REQ-022 A shared package modexp_pkg shall hold WIDTH, NREQ, TIMEOUT defaults and the FSM state type.
REQ-023 The round-robin selection shall be one combinational sub-module, rr_picker (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-024 The bench shall cover these directed scenarios, with a behavioural engine model (MOD 998244353):
- Single request: req0 base=2, exp=10 -> req_ready[0] one cycle later; rsp_valid[0] with rsp_result=1024, rsp_err=0.
- Round-robin: all four valid at once (base=3, exp=i+1) -> service order 0,1,2,3 with results 3, 9, 27, 81; then 1 and 3 valid -> order 1,3.
- Stale done: model holds done 2 cycles after start drops -> exactly one rsp_valid; the next request is not completed early.
- Timeout: model never asserts done -> rsp_err=1 and rsp_result=0 after TIMEOUT cycles, eng_start low, then IDLE.
- Reset mid-run: rst during RUN -> all outputs 0 next cycle, no rsp_valid; the next request goes to requester 0 first.
- Edge operands: exp=0 -> 1; base=998244352, exp=2 -> 1.
